// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed synchronous data memory.
// Sub-word stores are done as read-modify-write because the memory has no byte enables.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] CAP   = 3'd2;
    localparam logic [2:0] MERGE = 3'd3;
    localparam logic [2:0] WR    = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and responses cannot be back-pressured.
    logic [2:0]  state;
    logic [2:0]  state_n;
    logic        accept;
    logic        req_err;
    logic        word_store;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [31:0] ld_fmt;
    logic [31:0] st_merge;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_addr_bits;

    assign req_ready        = (state == IDLE);
    assign accept           = req_valid && req_ready;
    assign mem_read         = (state == RD);
    assign mem_write        = (state == WR);
    assign dbg_state        = state;
    assign word_store       = req_we && (req_size == 2'b10);
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)         state_n = RESP;
                    else if (word_store) state_n = WR;
                    else                 state_n = RD;
                end
            end
            RD:      state_n = we_q ? MERGE : CAP;
            CAP:     state_n = RESP;
            MERGE:   state_n = WR;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Load formatting and store merge both work on the word returned by the RD cycle.
    always_comb begin
        ld_byte = mem_rdata[8*lane_q +: 8];
        ld_half = mem_rdata[16*lane_q[1] +: 16];
        case (size_q)
            2'b00:   ld_fmt = {{24{sgn_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{sgn_q & ld_half[15]}}, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
        st_merge = mem_rdata;
        if (size_q == 2'b00) st_merge[8*lane_q +: 8] = wdata_q[7:0];
        else                 st_merge[16*lane_q[1] +: 16] = wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sgn_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 16'h0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            state <= state_n;
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                sgn_q    <= req_signed;
                lane_q   <= req_addr[1:0];
                wdata_q  <= req_wdata[15:0];
                mem_addr <= req_addr[ADDR_W+1:2];
                if (word_store && !req_err) mem_wdata <= req_wdata;
            end
            if (state == MERGE) mem_wdata <= st_merge;
            resp_valid <= (state_n == RESP);
            // Only the error path jumps straight from IDLE to RESP.
            resp_err   <= (state_n == RESP) && (state == IDLE);
            if (state == CAP)       resp_rdata <= ld_fmt;
            else if (state == RESP) resp_rdata <= 32'h0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 256-word synchronous memory, directed scenarios,
// and randomized traffic checked against a byte-array model of memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    logic [31:0] dmem [0:255] = '{default: 32'h0};
    logic [7:0]  ref_mem [0:1023] = '{default: 8'h0};
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    int          obs_rd_cyc, obs_wr_cyc, obs_resp_cyc, obs_rd_cnt, obs_wr_cnt;
    logic [7:0]  obs_rd_addr, obs_wr_addr;
    logic [31:0] obs_wr_data, obs_rdata, obs_rdata_after;
    logic        obs_err, obs_valid_after, obs_ready_after, obs_ready_before;

    logic        exp_err;
    logic [31:0] exp_rdata, exp_word;
    int          exp_lat, exp_waddr;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // clock / memory
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= dmem[mem_addr];
    end

    // reference model: memory as 1024 bytes, little-endian
    task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int base, n;
        logic [31:0] v;
        base = int'(addr % 32'd1024);
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_err   = (size == 2'd3) || ((addr % n) != 0);
        exp_waddr = base / 4;
        exp_rdata = 32'h0;
        exp_word  = 32'h0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = 8'((wdata >> (8 * i)) & 32'hFF);
            for (int j = 0; j < 4; j++) exp_word = exp_word | (32'(ref_mem[exp_waddr * 4 + j]) << (8 * j));
            exp_lat = (n == 4) ? 2 : 4;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
            if (sgn && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
            exp_rdata = v;
            exp_lat   = 3;
        end
    endtask

    // driver: issue one request, watch the memory port and response cycle by cycle
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        obs_rd_cyc = 0; obs_wr_cyc = 0; obs_resp_cyc = 0; obs_rd_cnt = 0; obs_wr_cnt = 0;
        obs_rd_addr = 8'h0; obs_wr_addr = 8'h0; obs_wr_data = 32'h0; obs_rdata = 32'h0; obs_err = 1'b0;
        @(negedge clk);
        obs_ready_before = req_ready;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        for (int k = 1; k <= 10 && obs_resp_cyc == 0; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (mem_read)  begin obs_rd_cnt++; obs_rd_cyc = k; obs_rd_addr = mem_addr; end
            if (mem_write) begin obs_wr_cnt++; obs_wr_cyc = k; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata; end
            if (resp_valid) begin obs_resp_cyc = k; obs_rdata = resp_rdata; obs_err = resp_err; end
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        obs_valid_after = resp_valid;
        obs_ready_after = req_ready;
        obs_rdata_after = resp_rdata;
        if (mem_read)  obs_rd_cnt++;
        if (mem_write) obs_wr_cnt++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else n_pass++;
        n_checks++; if ({resp_valid, resp_err, resp_rdata} !== 34'h0) $display("FAIL reset_resp: got %b/%b/%h expected 0/0/0", resp_valid, resp_err, resp_rdata); else n_pass++;
        n_checks++; if ({mem_read, mem_write, mem_addr, mem_wdata} !== 42'h0) $display("FAIL reset_mem: got %b/%b/%h/%h expected all 0", mem_read, mem_write, mem_addr, mem_wdata); else n_pass++;
    endtask

    task automatic test_word_store_load();
        model_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        n_checks++; if (obs_wr_cyc !== 1 || obs_wr_cnt !== 1) $display("FAIL sw_write_cycle: got cycle %0d count %0d expected cycle 1 count 1", obs_wr_cyc, obs_wr_cnt); else n_pass++;
        n_checks++; if (obs_wr_addr !== 8'h04 || obs_wr_data !== 32'hDEADBEEF) $display("FAIL sw_write_data: got %h/%h expected 04/deadbeef", obs_wr_addr, obs_wr_data); else n_pass++;
        n_checks++; if (obs_resp_cyc !== 2 || obs_err !== 1'b0 || obs_rdata !== 32'h0) $display("FAIL sw_resp: got cycle %0d err %b rdata %h expected 2/0/0", obs_resp_cyc, obs_err, obs_rdata); else n_pass++;
        n_checks++; if (obs_rd_cnt !== 0) $display("FAIL sw_no_read: got %0d reads expected 0", obs_rd_cnt); else n_pass++;
        model_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        n_checks++; if (obs_rd_cyc !== 1 || obs_rd_addr !== 8'h04) $display("FAIL lw_read: got cycle %0d addr %h expected 1/04", obs_rd_cyc, obs_rd_addr); else n_pass++;
        n_checks++; if (obs_resp_cyc !== 3 || obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) $display("FAIL lw_resp: got cycle %0d rdata %h err %b expected 3/deadbeef/0", obs_resp_cyc, obs_rdata, obs_err); else n_pass++;
        n_checks++; if (obs_valid_after !== 1'b0 || obs_rdata_after !== 32'h0 || obs_ready_after !== 1'b1) $display("FAIL lw_after_resp: got valid %b rdata %h ready %b expected 0/0/1", obs_valid_after, obs_rdata_after, obs_ready_after); else n_pass++;
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad  [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] ex  [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hFFFFFFEF};
        for (int i = 0; i < 5; i++) begin
            model_req(1'b0, sz[i], sg[i], ad[i], 32'h0);
            issue(1'b0, sz[i], sg[i], ad[i], 32'h0, 1'b0);
            n_checks++; if (obs_rdata !== ex[i] || obs_resp_cyc !== 3 || obs_err !== 1'b0) $display("FAIL load_ext_%0d: got %h cycle %0d err %b expected %h cycle 3 err 0", i, obs_rdata, obs_resp_cyc, obs_err, ex[i]); else n_pass++;
        end
    endtask

    task automatic test_subword_store();
        model_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345655);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345655, 1'b0);
        n_checks++; if (obs_rd_cyc !== 1 || obs_wr_cyc !== 3 || obs_resp_cyc !== 4) $display("FAIL sb_timing: got rd %0d wr %0d resp %0d expected 1/3/4", obs_rd_cyc, obs_wr_cyc, obs_resp_cyc); else n_pass++;
        n_checks++; if (obs_wr_data !== 32'hDEAD55EF || obs_wr_addr !== 8'h04) $display("FAIL sb_merge: got %h at %h expected deadbeef->dead55ef at 04", obs_wr_data, obs_wr_addr); else n_pass++;
        n_checks++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0) $display("FAIL sb_resp: got err %b rdata %h expected 0/0", obs_err, obs_rdata); else n_pass++;
        model_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234);
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, 1'b0);
        n_checks++; if (obs_wr_data !== 32'h123455EF) $display("FAIL sh_merge: got %h expected 123455ef", obs_wr_data); else n_pass++;
        model_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        n_checks++; if (obs_rdata !== 32'h123455EF) $display("FAIL sh_readback: got %h expected 123455ef", obs_rdata); else n_pass++;
    endtask

    task automatic test_errors();
        logic        we [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3] = '{32'h12, 32'h11, 32'h0};
        for (int i = 0; i < 3; i++) begin
            model_req(we[i], sz[i], 1'b1, ad[i], 32'hFFFF_FFFF);
            issue(we[i], sz[i], 1'b1, ad[i], 32'hFFFF_FFFF, 1'b0);
            n_checks++; if (obs_resp_cyc !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) $display("FAIL err_resp_%0d: got cycle %0d err %b rdata %h expected 1/1/0", i, obs_resp_cyc, obs_err, obs_rdata); else n_pass++;
            n_checks++; if (obs_rd_cnt !== 0 || obs_wr_cnt !== 0) $display("FAIL err_no_access_%0d: got %0d reads %0d writes expected 0/0", i, obs_rd_cnt, obs_wr_cnt); else n_pass++;
        end
    endtask

    task automatic test_wrap_hold();
        model_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5A5A5);
        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5A5A5, 1'b1);
        n_checks++; if (obs_wr_addr !== 8'h00 || obs_wr_cnt !== 1) $display("FAIL wrap_write: got addr %h count %0d expected 00/1", obs_wr_addr, obs_wr_cnt); else n_pass++;
        n_checks++; if (obs_resp_cyc !== 2 || obs_valid_after !== 1'b0 || obs_ready_after !== 1'b1) $display("FAIL hold_single_accept: got resp %0d valid_after %b ready %b expected 2/0/1", obs_resp_cyc, obs_valid_after, obs_ready_after); else n_pass++;
        model_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        n_checks++; if (obs_rdata !== 32'hA5A5A5A5 || obs_rd_cnt !== 1) $display("FAIL wrap_readback: got %h reads %0d expected a5a5a5a5/1", obs_rdata, obs_rd_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int bad_wr, bad_resp;
        bad_wr = 0; bad_resp = 0;
        // sub-word store aborted during MERGE
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h77;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        n_checks++; if (req_ready !== 1'b1 || mem_write !== 1'b0 || resp_valid !== 1'b0) $display("FAIL rst_async: got ready %b wr %b valid %b expected 1/0/0", req_ready, mem_write, resp_valid); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (mem_write) bad_wr++;
            if (resp_valid) bad_resp++;
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b expected 1", req_ready); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (mem_write) bad_wr++;
            if (resp_valid) bad_resp++;
        end
        n_checks++; if (bad_wr !== 0 || bad_resp !== 0) $display("FAIL rst_no_effect: got %0d writes %0d responses expected 0/0", bad_wr, bad_resp); else n_pass++;
        // load aborted during RD: mem_read must drop with rst_n
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20;
        @(posedge clk); #1; req_valid = 1'b0; #2;
        rst_n = 1'b0; #1;
        n_checks++; if (mem_read !== 1'b0) $display("FAIL rst_read_drop: got %b expected 0", mem_read); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        model_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        n_checks++; if (obs_rdata !== exp_rdata || obs_resp_cyc !== 3) $display("FAIL rst_word_intact: got %h cycle %0d expected %h cycle 3", obs_rdata, obs_resp_cyc, exp_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        logic        we, sgn;
        logic [1:0]  sz;
        logic [31:0] ad, wd, exp_v;
        int          errs;
        errs = 0;
        for (int i = 0; i < 80; i++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            sgn = 1'($urandom_range(0, 1));
            ad  = 32'($urandom_range(0, 47));
            if ($urandom_range(0, 3) == 0) ad = ad | ($urandom & 32'hFFFF_FC00);
            wd  = $urandom;
            model_req(we, sz, sgn, ad, wd);
            exp_q.push_back(exp_rdata);
            issue(we, sz, sgn, ad, wd, 1'b0);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_ready_before !== 1'b1 || obs_resp_cyc !== exp_lat || obs_err !== exp_err || obs_rdata !== exp_v) begin
                $display("FAIL rand_%0d resp: got ready %b cycle %0d err %b rdata %h expected 1/%0d/%b/%h (we %b sz %0d addr %h)",
                         i, obs_ready_before, obs_resp_cyc, obs_err, obs_rdata, exp_lat, exp_err, exp_v, we, sz, ad);
                errs++;
            end else n_pass++;
            if (we && !exp_err) begin
                n_checks++;
                if (obs_wr_cnt !== 1 || obs_wr_addr !== 8'(exp_waddr) || obs_wr_data !== exp_word)
                    $display("FAIL rand_%0d write: got count %0d addr %h data %h expected 1/%h/%h", i, obs_wr_cnt, obs_wr_addr, obs_wr_data, 8'(exp_waddr), exp_word);
                else n_pass++;
            end else begin
                n_checks++;
                if (obs_wr_cnt !== 0) $display("FAIL rand_%0d no_write: got %0d writes expected 0", i, obs_wr_cnt); else n_pass++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_word_store_load();
        test_load_ext();
        test_subword_store();
        test_errors();
        test_wrap_hold();
        test_reset_mid_op();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM-stage control of the 32-bit MIPS core and the word-addressed data memory (256 x 32-bit, synchronous read and write).
- Accepts byte-addressed load/store requests of size byte, half or word, with sign- or zero-extension on loads.
- Generates the memory's mem_read/mem_write/addr/data_in and formats its data_out into the response.
- Performs sub-word stores as read-modify-write, because the memory has no byte enables.

Parameters:
- ADDR_W, 8, word-address width driven to data memory (memory depth = 2^ADDR_W words).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle and able to accept
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  formatted load data (0 for stores and errors)
- resp_err  output  1  misaligned or illegal-size request, qualified by resp_valid
- mem_read  output  1  to data memory
- mem_write  output  1  to data memory
- mem_addr  output  ADDR_W  word address to data memory
- mem_wdata  output  32  to data memory data_in
- mem_rdata  input  32  from data memory data_out; valid the cycle after mem_read

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - State = IDLE, so req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
- Outputs:
  - mem_read/mem_write are decoded from state only and are never both 1.
  - mem_addr, mem_wdata and resp_* are registered.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready. All request fields are latched at that edge.
  - req_ready = 1 only in IDLE. req_valid while busy is ignored.
  - There is no response backpressure.
- Address mapping:
  - mem_addr = req_addr[ADDR_W+1:2]. Higher bits are ignored, so addresses wrap modulo 4*2^ADDR_W bytes.
  - Lanes are little-endian: byte k = bits [8k+7:8k]; half at addr[1] = bits [16*addr[1]+15 : 16*addr[1]].
- Error conditions:
  - half with addr[0] = 1.
  - word with addr[1:0] != 0.
  - size = 11.
  - Any of these sets err = 1; the request makes no memory access.
- States: IDLE, RD, CAP, MERGE, WR, RESP.
  - IDLE -> RESP on accept with err.
  - IDLE -> WR on accept of a word store.
  - IDLE -> RD on accept of a load or a sub-word store.
  - RD: mem_read = 1. Next state CAP for a load, MERGE for a store.
  - CAP: formats mem_rdata into resp_rdata. Next state RESP.
    - Byte/half extraction is selected by address lane.
    - Extension follows req_signed (lb, lbu, lh, lhu).
    - Word is passed unchanged; req_signed is ignored.
  - MERGE: mem_wdata = mem_rdata with the addressed lane replaced by req_wdata[7:0] (byte) or [15:0] (half); other bits are preserved. Next state WR.
  - WR: mem_write = 1, with mem_wdata = req_wdata for word stores. Next state RESP.
  - RESP: resp_valid = 1 for exactly one cycle; resp_err as latched. Next state IDLE.
  - resp_valid, resp_err and resp_rdata return to 0 in the cycle after RESP.
- Latency (cycle 0 = accept cycle; resp_valid high in cycle N):
  - Error: N = 1.
  - Word store: N = 2; mem_write in cycle 1.
  - Load: N = 3; mem_read in cycle 1.
  - Sub-word store: N = 4; mem_read in cycle 1, mem_write in cycle 3.
- Back-to-back: a new request can be accepted in the cycle after RESP. A load directly after a store observes the stored data.
- Reset mid-operation:
  - State returns to IDLE immediately, and mem_read/mem_write drop asynchronously.
  - An RMW interrupted before WR performs no write.
  - No resp_valid is produced for the aborted request.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> mem_write in cycle 1 with mem_addr 0x04; load resp_rdata = 0xDEADBEEF, resp_valid in cycle 3, resp_err = 0.
- With word 0x04 = 0xDEADBEEF:
  - lb 0x13 -> 0xFFFFFFDE
  - lbu 0x13 -> 0x000000DE
  - lh 0x12 -> 0xFFFFDEAD
  - lhu 0x10 -> 0x0000BEEF
  - lb 0x10 -> 0xFFFFFFEF
- sb 0x11 data 0x12345655 -> mem_read in cycle 1, mem_write in cycle 3 with mem_wdata 0xDEAD55EF, resp in cycle 4. Then sh 0x12 data 0x1234 -> word 0x04 = 0x123455EF.
- Each of lw 0x12, sh 0x11, and size = 11 at 0x0 -> resp_valid and resp_err = 1 in cycle 1; mem_read/mem_write stay 0; resp_rdata = 0.
- sw 0x400 data 0xA5A5A5A5 (ADDR_W = 8) -> mem_addr 0x00. Then lw 0x0 returns 0xA5A5A5A5. req_valid held high during busy cycles is not accepted twice.
- Issue sb, then pull rst_n low during MERGE -> mem_write never asserts, resp_valid stays 0, req_ready = 1 immediately after rst_n rises.
